rvga_debug_trace: RTL and testbench
===================================

Name: rvga_debug_trace

Overview:
- Parametrised instruction-trace buffer fed by the decoded-instruction debug bus; one record per retired instruction, packed by the caller into a flat REC_W vector.
- Record bits [6:0] carry the RV opcode.
- Captures records into a DEPTH-entry circular buffer, with opcode/mask triggering, a post-trigger capture window, and ring or fill-stop modes.
- The frozen trace is drained by the debug module through a valid/yumi pop port.

Parameters:
- REC_W, 32, width of one trace record; must be at least 7.
- DEPTH, 16, number of buffer entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy and post-count fields (derived).

Ports:
- clk  in  1  Clock.
- rst  in  1  Synchronous, active-high reset.
- cap_v_i  in  1  A record is presented this cycle.
- cap_rec_i  in  REC_W  Record; bits [6:0] are the opcode.
- arm_i  in  1  Pulse: clear the buffer and enter ARMED.
- mode_i  in  1  0 = ring (overwrite oldest), 1 = fill-stop; sampled on arm_i.
- trig_opcode_i  in  7  Trigger opcode value; sampled on arm_i.
- trig_mask_i  in  7  Bit = 1 means compare that opcode bit; sampled on arm_i.
- post_cnt_i  in  CNT_W  Records captured after the trigger record; saturates at DEPTH-1; sampled on arm_i.
- rd_v_o  out  1  Oldest record is available.
- rd_rec_o  out  REC_W  Oldest record; 0 when rd_v_o = 0.
- rd_yumi_i  in  1  Pop the oldest record; legal only when rd_v_o = 1.
- count_o  out  CNT_W  Entries currently held.
- state_o  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- overflow_o  out  1  Sticky: ring mode overwrote at least one entry since the last arm.

Behaviour:
- Reset (sync, priority over everything): state IDLE, wr_ptr = rd_ptr = 0, count_o = 0, overflow_o = 0, post counter 0, rd_v_o = 0, rd_rec_o = 0. Reset mid-capture or mid-drain discards all contents.
- Capture condition: cap_v_i = 1 and state is ARMED or POST. The record is written at wr_ptr; wr_ptr increments mod DEPTH; count_o is updated in the next cycle (1-cycle latency).
- Trigger: a captured record in ARMED with ((cap_rec_i[6:0] ^ trig_opcode) & trig_mask) == 0. Mask 0 triggers on the first captured record. The trigger record itself is stored.
- IDLE: cap_v_i ignored; on arm_i go to ARMED.
- ARMED, trigger with post = 0: go to DONE.
- ARMED, trigger with post > 0: load the post counter, go to POST.
- ARMED, ring mode and full: write at wr_ptr, rd_ptr increments, count stays DEPTH, overflow_o is set.
- ARMED, fill-stop mode: the record that makes count = DEPTH is stored, then go to DONE whether or not it triggered.
- POST: each capture decrements the post counter; when it reaches 0, go to DONE.
- POST, ring mode and full: overwrite as in ARMED.
- POST, fill-stop mode and full: go to DONE immediately.
- DONE: capture is disabled. rd_v_o = (count_o != 0); rd_rec_o = mem[rd_ptr], combinational from the registered pointer. rd_yumi_i advances rd_ptr mod DEPTH and decrements count. After draining, stay in DONE.
- Pops are accepted only in DONE. rd_yumi_i with rd_v_o = 0 is ignored.
- arm_i in any state: pointers, count and overflow clear, configuration is resampled, state becomes ARMED. A cap_v_i or rd_yumi_i in the same cycle is dropped.
- Wrap-around: both pointers wrap mod DEPTH. Full vs empty is distinguished by count_o, never by pointer equality.
- Storage: flop or distributed-RAM array. It needs no reset; only pointers, count and state reset.

Test Plan:
- Reset: rst high for 2 cycles, then low -> state_o = 0, count_o = 0, rd_v_o = 0, overflow_o = 0. cap_v_i pulses while IDLE -> count_o stays 0.
- Basic trigger (DEPTH = 8): arm with mode 0, trig_opcode 7'h63, mask 7'h7F, post 2. Send opcodes 13, 33, 63, 03, 23 -> after the 63, state_o = 2; after the 23, state_o = 3 and count_o = 5. Pop 5 times -> records appear in order 13, 33, 63, 03, 23, then rd_v_o = 0.
- Ring overflow (DEPTH = 8): arm with mode 0, mask 7'h7F, trig 7'h6F. Send records 0..11 (opcode 13), then one 6F with post 0 -> count_o = 8, overflow_o = 1. Drain returns records 5..11 then the 6F.
- Fill-stop: arm with mode 1, a trigger that never matches, then 10 records -> DONE after the 8th. count_o = 8, overflow_o = 0. Records 9 and 10 are not stored.
- Mask 0 with post 0: arm, then a single record -> state DONE the next cycle, count_o = 1.
- Re-arm mid-POST with simultaneous cap_v_i -> state_o = 1, count_o = 0, overflow_o = 0, and the concurrent record is not stored.

Source files
------------

// File: rtl/rvga_debug_trace.sv
// Instruction-trace buffer: captures retired-instruction records into a circular
// buffer, freezes on an opcode trigger plus post-window, then drains via valid/yumi.
module rvga_debug_trace #(
  parameter int REC_W = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_v_i,
  input  logic [REC_W-1:0] cap_rec_i,
  input  logic             arm_i,
  input  logic             mode_i,
  input  logic [6:0]       trig_opcode_i,
  input  logic [6:0]       trig_mask_i,
  input  logic [CNT_W-1:0] post_cnt_i,
  output logic             rd_v_o,
  output logic [REC_W-1:0] rd_rec_o,
  input  logic             rd_yumi_i,
  output logic [CNT_W-1:0] count_o,
  output logic [1:0]       state_o,
  output logic             overflow_o
);

  // state | meaning
  // IDLE  | not capturing, waiting for arm
  // ARMED | capturing, watching for the trigger opcode
  // POST  | trigger seen, capturing the post-trigger window
  // DONE  | trace frozen, available for draining
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  logic [1:0]       state, state_nxt;
  logic [REC_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, post_ctr, cfg_post, post_sat;
  logic             cfg_mode, overflow;
  logic [6:0]       cfg_op, cfg_mask;
  logic             capturing, full, wr_en, trig_hit, pop, fill_last;

  assign capturing = cap_v_i && !arm_i && (state == S_ARMED || state == S_POST);
  assign full      = (count == FULL_CNT);
  // fill-stop never overwrites; ring mode always writes
  assign wr_en     = capturing && !(cfg_mode && full);
  assign trig_hit  = (state == S_ARMED) && wr_en &&
                     (((cap_rec_i[6:0] ^ cfg_op) & cfg_mask) == 7'd0);
  assign pop       = (state == S_DONE) && rd_yumi_i && (count != '0) && !arm_i;
  assign fill_last = cfg_mode && (count == LAST_CNT);
  assign post_sat  = (post_cnt_i > LAST_CNT) ? LAST_CNT : post_cnt_i;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (arm_i) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_ARMED: begin
          if (wr_en) begin
            if (fill_last)     state_nxt = S_DONE;
            else if (trig_hit) state_nxt = (cfg_post == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (capturing && ((cfg_mode && full) || fill_last || post_ctr == CNT_W'(1)))
            state_nxt = S_DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    state_o    = state;
    count_o    = count;
    overflow_o = overflow;
    rd_v_o     = (state == S_DONE) && (count != '0);
    rd_rec_o   = rd_v_o ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_ctr <= '0;
      cfg_mode <= 1'b0;
      cfg_op   <= '0;
      cfg_mask <= '0;
      cfg_post <= '0;
    end else if (arm_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_ctr <= '0;
      cfg_mode <= mode_i;
      cfg_op   <= trig_opcode_i;
      cfg_mask <= trig_mask_i;
      cfg_post <= post_sat;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (full) begin
          rd_ptr   <= rd_ptr + PW'(1);
          overflow <= 1'b1;
        end
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      if (wr_en && !full) count <= count + CNT_W'(1);
      else if (pop)       count <= count - CNT_W'(1);

      if (trig_hit)
        post_ctr <= cfg_post;
      else if (state == S_POST && wr_en && post_ctr != '0)
        post_ctr <= post_ctr - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= cap_rec_i;
  end

endmodule

// File: tb/tb_rvga_debug_trace.sv
// Directed bench for rvga_debug_trace at DEPTH = 8: trigger, ring overflow,
// fill-stop, mask-0 trigger and re-arm during the post window.
module tb_rvga_debug_trace;
  localparam int REC_W = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             cap_v;
  logic [REC_W-1:0] cap_rec;
  logic             arm;
  logic             mode;
  logic [6:0]       trig_opcode, trig_mask;
  logic [CNT_W-1:0] post_cnt;
  logic             rd_v;
  logic [REC_W-1:0] rd_rec;
  logic             rd_yumi;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;

  rvga_debug_trace #(.REC_W(REC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cap_v_i(cap_v), .cap_rec_i(cap_rec), .arm_i(arm),
    .mode_i(mode), .trig_opcode_i(trig_opcode), .trig_mask_i(trig_mask),
    .post_cnt_i(post_cnt), .rd_v_o(rd_v), .rd_rec_o(rd_rec), .rd_yumi_i(rd_yumi),
    .count_o(count), .state_o(state), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic m, input logic [6:0] op, input logic [6:0] msk,
                        input logic [CNT_W-1:0] post);
    arm = 1'b1; mode = m; trig_opcode = op; trig_mask = msk; post_cnt = post;
    tick();
    arm = 1'b0;
  endtask

  task automatic cap(input logic [REC_W-1:0] rec);
    cap_v = 1'b1; cap_rec = rec;
    tick();
    cap_v = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [REC_W-1:0] exp);
    check({tag, "_v"}, 32'(rd_v), 32'd1);
    check({tag, "_rec"}, rd_rec, exp);
    rd_yumi = 1'b1;
    tick();
    rd_yumi = 1'b0;
  endtask

  function automatic logic [REC_W-1:0] rec13(input int i);
    return (REC_W'(i) << 7) | REC_W'(32'h13);
  endfunction

  initial begin
    rst = 1'b1; cap_v = 1'b0; cap_rec = '0; arm = 1'b0; mode = 1'b0;
    trig_opcode = '0; trig_mask = '0; post_cnt = '0; rd_yumi = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_v", 32'(rd_v), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_rd_rec", rd_rec, 32'd0);
    cap(32'h13); cap(32'h33);
    check("idle_count", 32'(count), 32'd0);

    // basic trigger with post window of 2
    do_arm(1'b0, 7'h63, 7'h7F, 4'd2);
    check("arm_state", 32'(state), 32'd1);
    cap(32'h13); cap(32'h33); cap(32'h63);
    check("trig_state", 32'(state), 32'd2);
    cap(32'h03);
    check("post_state", 32'(state), 32'd2);
    cap(32'h23);
    check("done_state", 32'(state), 32'd3);
    check("done_count", 32'(count), 32'd5);
    pop_expect("b0", 32'h13);
    pop_expect("b1", 32'h33);
    pop_expect("b2", 32'h63);
    pop_expect("b3", 32'h03);
    pop_expect("b4", 32'h23);
    check("b_empty_v", 32'(rd_v), 32'd0);
    check("b_empty_cnt", 32'(count), 32'd0);
    check("b_empty_rec", rd_rec, 32'd0);
    rd_yumi = 1'b1; tick(); rd_yumi = 1'b0;
    check("b_ign_yumi_cnt", 32'(count), 32'd0);
    check("b_stay_done", 32'(state), 32'd3);

    // ring overflow: 12 records into 8 entries, then the trigger
    do_arm(1'b0, 7'h6F, 7'h7F, 4'd0);
    for (int i = 0; i < 12; i++) cap(rec13(i));
    check("ring_state", 32'(state), 32'd1);
    check("ring_count", 32'(count), 32'd8);
    check("ring_ovf", 32'(overflow), 32'd1);
    cap(32'h0000_006F);
    check("ring_done", 32'(state), 32'd3);
    check("ring_count2", 32'(count), 32'd8);
    for (int i = 5; i < 12; i++) pop_expect($sformatf("r%0d", i), rec13(i));
    pop_expect("r_trig", 32'h6F);
    check("ring_empty", 32'(rd_v), 32'd0);

    // fill-stop with a trigger that never matches
    do_arm(1'b1, 7'h7F, 7'h7F, 4'd0);
    check("fill_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      cap(rec13(i));
      if (i == 7) check("fill_pre_state", 32'(state), 32'd1);
      if (i == 8) check("fill_state8", 32'(state), 32'd3);
    end
    check("fill_count", 32'(count), 32'd8);
    check("fill_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= 8; i++) pop_expect($sformatf("f%0d", i), rec13(i));
    check("fill_empty", 32'(rd_v), 32'd0);

    // mask 0, post 0: first record triggers
    do_arm(1'b0, 7'h00, 7'h00, 4'd0);
    cap(32'hABCD_0037);
    check("m0_state", 32'(state), 32'd3);
    check("m0_count", 32'(count), 32'd1);
    pop_expect("m0", 32'hABCD_0037);

    // post saturates at DEPTH-1: 1 trigger + 7 post records
    do_arm(1'b0, 7'h63, 7'h7F, 4'd15);
    cap(32'h63);
    for (int i = 0; i < 6; i++) cap(rec13(i));
    check("sat_state6", 32'(state), 32'd2);
    cap(rec13(6));
    check("sat_state7", 32'(state), 32'd3);
    check("sat_count", 32'(count), 32'd8);

    // re-arm during POST with a concurrent capture
    do_arm(1'b0, 7'h63, 7'h7F, 4'd3);
    cap(32'h13); cap(32'h63);
    check("rearm_post", 32'(state), 32'd2);
    arm = 1'b1; mode = 1'b0; trig_opcode = 7'h00; trig_mask = 7'h00; post_cnt = 4'd0;
    cap_v = 1'b1; cap_rec = 32'hDEAD_0013;
    tick();
    arm = 1'b0; cap_v = 1'b0;
    check("rearm_state", 32'(state), 32'd1);
    check("rearm_count", 32'(count), 32'd0);
    check("rearm_ovf", 32'(overflow), 32'd0);
    cap(32'h0000_1133);
    check("rearm_done", 32'(state), 32'd3);
    check("rearm_count1", 32'(count), 32'd1);
    pop_expect("rearm_rec", 32'h0000_1133);

    // reset discards a frozen trace
    do_arm(1'b0, 7'h00, 7'h00, 4'd0);
    cap(32'h13);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_state", 32'(state), 32'd0);
    check("rst2_count", 32'(count), 32'd0);
    check("rst2_rd_v", 32'(rd_v), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
